decode_writeback: RTL and testbench
===================================

# decode_writeback

Combined decode and write-back stage of the sequential Y86-64 processor, sitting directly downstream of instruction fetch. It owns the fifteen 64-bit program registers. From the fetched icode/ifun/rA/rB it combinationally selects source and destination registers and drives valA/valB to execute. On each rising clock edge it commits valE and valM from execute/memory into the register file.

## Interface
- DATA_W, 64, register and data-path width.
- RSP_ID, 4'h4, register number of %rsp.
- NONE_ID, 4'hF, register ID meaning "no register"; reads return 0 and writes are dropped.

Ports:
- clk  in  1  single clock; all register writes occur on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- icode  in  4  instruction code from fetch.
- ifun  in  4  function code from fetch (unused except pass-through).
- rA, rB  in  4 each  register specifiers from fetch.
- cnd  in  1  condition result from execute (gates cmovXX).
- valE  in  DATA_W  ALU result.
- valM  in  DATA_W  memory read result.
- wb_en  in  1  commit enable; low on halt, invalid instruction or memory error.
- valA, valB  out  DATA_W  operand values (combinational).
- srcA, srcB, dstE, dstM  out  4 each  selected register IDs (combinational, for debug/verification).
- dbg_addr  in  4  debug read address.
- dbg_data  out  DATA_W  register file content at dbg_addr (0 for 4'hF).

## Operation
- **srcA**
  - rA for icode 2 (cmov/rrmov), 4 (rmmov), 6 (OPq), A (pushq).
  - RSP_ID for 9 (ret) and B (popq).
  - NONE_ID otherwise.
- **srcB**
  - rB for 4, 5 (mrmov), 6.
  - RSP_ID for 8 (call), 9, A, B.
  - NONE_ID otherwise.
- **dstE**
  - For icode 2: rB if cnd, else NONE_ID.
  - rB for 3 (irmov) and 6.
  - RSP_ID for 8, 9, A, B.
  - NONE_ID otherwise.
- **dstM**: rA for 5 and B; NONE_ID otherwise.
- **Reads**
  - valA = regs[srcA] and valB = regs[srcB].
  - Either reads 0 when its ID equals NONE_ID.
- **Writes** at posedge clk when wb_en=1:
  - regs[dstE] <= valE if dstE != NONE_ID.
  - regs[dstM] <= valM if dstM != NONE_ID.
- **Write conflict**: if dstE == dstM != NONE_ID (popq %rsp), valM wins.
- **Disabled commit**: wb_en=0 suppresses all writes; the register file holds its state.
- **Unused codes**: icodes 0, 1 and C–F select NONE_ID for all four IDs and write nothing.
- **Reset**: rst=1 asynchronously clears all 15 registers to 0.
  - While rst is high, writes are blocked regardless of wb_en.
  - Outputs after reset: valA=valB=dbg_data=0; ID outputs follow inputs.

## Timing
- **Decode path**: purely combinational, zero latency from icode/rA/rB/cnd to src*/dst*/valA/valB.
- **Write-back latency**: one edge. Values written at edge N are visible on valA/valB/dbg_data immediately after edge N.
- **No bypass**: a same-cycle read of a register being written returns the pre-edge value.
- **Reset timing**:
  - Assertion takes effect without a clock edge.
  - Deassertion is sampled normally; the first write can occur on the first rising edge with rst low.
- **Reset mid-operation**: a write pending at the edge coincident with rst high is discarded.

## Test plan
- **Reset**: assert rst asynchronously between edges with registers non-zero -> dbg_data reads 0 for every address before the next edge; valA=valB=0.
- **irmovq then OPq**
  - irmovq: icode=3, rB=2, valE=64'h1234, wb_en=1, one edge -> dbg_addr=2 reads 64'h1234.
  - OPq: icode=6, rA=2, rB=2 -> srcA=srcB=2 and valA=valB=64'h1234.
- **popq %rsp**: icode=B, rA=4, valE=64'h108, valM=64'hDEAD, one edge -> regs[4]=64'hDEAD, not 64'h108.
- **cmov with cnd=0**: icode=2, rA=1, rB=3, cnd=0, valE=64'h55, edge -> regs[3] unchanged and dstE=4'hF. Repeat with cnd=1 -> regs[3]=64'h55.
- **Disabled commit**: wb_en=0 with icode=3, rB=5, valE=64'h77, edge -> regs[5] unchanged. Separately, halt icode=0 with wb_en=1 -> all IDs=4'hF and no register changes.
- **Same-cycle read/write**: OPq with rA=rB=7 and valE=64'h9. Before the edge valA shows the old value; after the edge it shows 64'h9. Raise rst concurrently with a write edge -> register ends at 0.

Source files
------------

// File: rtl/decode_writeback.sv
// ---------------------------------------------------------------------------
// decode_writeback
//   Decode and write-back stage of a sequential Y86-64 core. It holds the
//   fifteen 64-bit program registers. From fetch it selects the source and
//   destination register IDs and drives the operand values valA/valB
//   combinationally. On each rising clock edge it commits valE and valM.
//
// Ports
//   clk        clock; register writes happen on its rising edge
//   rst        asynchronous active-high reset; clears the register file
//   icode      instruction code from fetch
//   ifun       function code from fetch (not used by this stage)
//   rA, rB     register specifiers from fetch
//   cnd        condition flag from execute; gates cmovXX write-back
//   valE       ALU result
//   valM       memory read result
//   wb_en      commit enable (low on halt / invalid instruction / mem error)
//   valA, valB operand values (combinational)
//   srcA, srcB selected source register IDs (combinational)
//   dstE, dstM selected destination register IDs (combinational)
//   dbg_addr   debug read address
//   dbg_data   register content at dbg_addr (0 for ID 4'hF)
// ---------------------------------------------------------------------------
module decode_writeback #(
    parameter int         DATA_W  = 64,
    parameter logic [3:0] RSP_ID  = 4'h4,
    parameter logic [3:0] NONE_ID = 4'hF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        icode,
    input  logic [3:0]        ifun,
    input  logic [3:0]        rA,
    input  logic [3:0]        rB,
    input  logic              cnd,
    input  logic [DATA_W-1:0] valE,
    input  logic [DATA_W-1:0] valM,
    input  logic              wb_en,
    output logic [DATA_W-1:0] valA,
    output logic [DATA_W-1:0] valB,
    output logic [3:0]        srcA,
    output logic [3:0]        srcB,
    output logic [3:0]        dstE,
    output logic [3:0]        dstM,
    input  logic [3:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    localparam int NUM_REGS = 15;

    localparam logic [3:0] I_RRMOV = 4'h2;
    localparam logic [3:0] I_IRMOV = 4'h3;
    localparam logic [3:0] I_RMMOV = 4'h4;
    localparam logic [3:0] I_MRMOV = 4'h5;
    localparam logic [3:0] I_OPQ   = 4'h6;
    localparam logic [3:0] I_CALL  = 4'h8;
    localparam logic [3:0] I_RET   = 4'h9;
    localparam logic [3:0] I_PUSH  = 4'hA;
    localparam logic [3:0] I_POP   = 4'hB;

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];

    // ifun only passes through this stage; fold it so nothing dangles
    logic unused_ifun;
    assign unused_ifun = ^ifun;

    // Register ID selection from the fetched instruction
    always_comb begin
        srcA = NONE_ID;
        srcB = NONE_ID;
        dstE = NONE_ID;
        dstM = NONE_ID;
        case (icode)
            I_RRMOV: begin
                srcA = rA;
                // cmovXX with a false condition writes nothing
                if (cnd) begin
                    dstE = rB;
                end else begin
                    dstE = NONE_ID;
                end
            end
            I_IRMOV: begin
                dstE = rB;
            end
            I_RMMOV: begin
                srcA = rA;
                srcB = rB;
            end
            I_MRMOV: begin
                srcB = rB;
                dstM = rA;
            end
            I_OPQ: begin
                srcA = rA;
                srcB = rB;
                dstE = rB;
            end
            I_CALL: begin
                srcB = RSP_ID;
                dstE = RSP_ID;
            end
            I_RET: begin
                srcA = RSP_ID;
                srcB = RSP_ID;
                dstE = RSP_ID;
            end
            I_PUSH: begin
                srcA = rA;
                srcB = RSP_ID;
                dstE = RSP_ID;
            end
            I_POP: begin
                srcA = RSP_ID;
                srcB = RSP_ID;
                dstE = RSP_ID;
                dstM = rA;
            end
            default: begin
                srcA = NONE_ID;
                srcB = NONE_ID;
                dstE = NONE_ID;
                dstM = NONE_ID;
            end
        endcase
    end

    // Register file read ports; ID 4'hF reads as zero
    always_comb begin
        valA     = {DATA_W{1'b0}};
        valB     = {DATA_W{1'b0}};
        dbg_data = {DATA_W{1'b0}};
        if (srcA != NONE_ID) begin
            valA = regs_q[srcA];
        end else begin
            valA = {DATA_W{1'b0}};
        end
        if (srcB != NONE_ID) begin
            valB = regs_q[srcB];
        end else begin
            valB = {DATA_W{1'b0}};
        end
        if (dbg_addr != NONE_ID) begin
            dbg_data = regs_q[dbg_addr];
        end else begin
            dbg_data = {DATA_W{1'b0}};
        end
    end

    // Next register file state; the M port is checked first so that
    // popq %rsp commits the popped value rather than the incremented pointer
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
            if (wb_en && (dstM != NONE_ID) && (dstM == 4'(i))) begin
                regs_d[i] = valM;
            end else if (wb_en && (dstE != NONE_ID) && (dstE == 4'(i))) begin
                regs_d[i] = valE;
            end else begin
                regs_d[i] = regs_q[i];
            end
        end
    end

    // Register file storage with asynchronous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= {DATA_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

endmodule

// File: tb/tb_decode_writeback.sv
`timescale 1ns/10ps
module tb_decode_writeback;

    logic        clk;
    logic        rst;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic        cnd;
    logic [63:0] vale;
    logic [63:0] valm;
    logic        wb_en;
    logic [63:0] vala;
    logic [63:0] valb;
    logic [3:0]  srca;
    logic [3:0]  srcb;
    logic [3:0]  dste;
    logic [3:0]  dstm;
    logic [3:0]  dbg_addr;
    logic [63:0] dbg_data;

    int n_checks;
    int n_errors;

    decode_writeback dut (
        .clk      (clk),
        .rst      (rst),
        .icode    (icode),
        .ifun     (ifun),
        .rA       (ra),
        .rB       (rb),
        .cnd      (cnd),
        .valE     (vale),
        .valM     (valm),
        .wb_en    (wb_en),
        .valA     (vala),
        .valB     (valb),
        .srcA     (srca),
        .srcB     (srcb),
        .dstE     (dste),
        .dstM     (dstm),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] ic, input logic [3:0] a, input logic [3:0] b,
                         input logic c, input logic [63:0] e, input logic [63:0] m,
                         input logic en);
        icode = ic;
        ifun  = 4'h0;
        ra    = a;
        rb    = b;
        cnd   = c;
        vale  = e;
        valm  = m;
        wb_en = en;
        #1;
    endtask

    // advance past the next rising edge, then let outputs settle
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic peek(input string tag, input logic [3:0] addr, input logic [63:0] exp);
        dbg_addr = addr;
        #0.1;
        chk(tag, dbg_data, exp);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst      = 1'b1;
        dbg_addr = 4'h0;
        drive(4'h0, 4'h0, 4'h0, 1'b0, 64'h0, 64'h0, 1'b1);
        chk("rst_vala", vala, 64'h0);
        chk("rst_valb", valb, 64'h0);
        chk("rst_dbg0", dbg_data, 64'h0);
        chk("halt_srca", {60'h0, srca}, 64'hF);
        chk("halt_dste", {60'h0, dste}, 64'hF);
        tick();
        peek("rst_hold_wr", 4'h0, 64'h0);
        @(negedge clk);
        rst = 1'b0;

        // irmovq $0x1234, %rdx
        drive(4'h3, 4'hF, 4'h2, 1'b0, 64'h1234, 64'h0, 1'b1);
        chk("irmov_dste", {60'h0, dste}, 64'h2);
        chk("irmov_srca", {60'h0, srca}, 64'hF);
        tick();
        peek("irmov_r2", 4'h2, 64'h1234);

        // OPq %rdx, %rdx reads the fresh value on both ports
        drive(4'h6, 4'h2, 4'h2, 1'b0, 64'h0, 64'h0, 1'b0);
        chk("opq_srca", {60'h0, srca}, 64'h2);
        chk("opq_srcb", {60'h0, srcb}, 64'h2);
        chk("opq_vala", vala, 64'h1234);
        chk("opq_valb", valb, 64'h1234);

        // popq %rsp: valM wins over valE
        drive(4'hB, 4'h4, 4'hF, 1'b0, 64'h108, 64'hDEAD, 1'b1);
        chk("pop_dste", {60'h0, dste}, 64'h4);
        chk("pop_dstm", {60'h0, dstm}, 64'h4);
        chk("pop_srca", {60'h0, srca}, 64'h4);
        tick();
        peek("pop_r4", 4'h4, 64'hDEAD);

        // preload %rbx, then cmov with false and true condition
        drive(4'h3, 4'hF, 4'h3, 1'b0, 64'h33, 64'h0, 1'b1);
        tick();
        drive(4'h2, 4'h1, 4'h3, 1'b0, 64'h55, 64'h0, 1'b1);
        chk("cmov0_dste", {60'h0, dste}, 64'hF);
        chk("cmov0_srca", {60'h0, srca}, 64'h1);
        tick();
        peek("cmov0_r3", 4'h3, 64'h33);
        drive(4'h2, 4'h1, 4'h3, 1'b1, 64'h55, 64'h0, 1'b1);
        chk("cmov1_dste", {60'h0, dste}, 64'h3);
        tick();
        peek("cmov1_r3", 4'h3, 64'h55);

        // disabled commit
        drive(4'h3, 4'hF, 4'h5, 1'b0, 64'h77, 64'h0, 1'b0);
        tick();
        peek("nowb_r5", 4'h5, 64'h0);

        // halt with wb_en high: no IDs, no writes
        drive(4'h0, 4'h2, 4'h3, 1'b1, 64'hBAD, 64'hBAD, 1'b1);
        chk("halt2_srcb", {60'h0, srcb}, 64'hF);
        chk("halt2_dstm", {60'h0, dstm}, 64'hF);
        chk("halt2_dste", {60'h0, dste}, 64'hF);
        tick();
        peek("halt2_r2", 4'h2, 64'h1234);
        peek("halt2_r3", 4'h3, 64'h55);
        peek("halt2_r4", 4'h4, 64'hDEAD);
        peek("dbg_none", 4'hF, 64'h0);

        // same-cycle read/write of %rdi, no bypass
        drive(4'h3, 4'hF, 4'h7, 1'b0, 64'h70, 64'h0, 1'b1);
        tick();
        drive(4'h6, 4'h7, 4'h7, 1'b0, 64'h9, 64'h0, 1'b1);
        chk("rw_pre_vala", vala, 64'h70);
        tick();
        chk("rw_post_vala", vala, 64'h9);
        chk("rw_post_valb", valb, 64'h9);

        // asynchronous reset between edges clears everything at once
        drive(4'h6, 4'h2, 4'h4, 1'b0, 64'h0, 64'h0, 1'b0);
        #1;
        rst = 1'b1;
        #0.5;
        chk("arst_vala", vala, 64'h0);
        chk("arst_valb", valb, 64'h0);
        for (int i = 0; i < 15; i++) begin
            peek($sformatf("arst_r%0d", i), 4'(i), 64'h0);
        end
        @(negedge clk);
        rst = 1'b0;

        // write lands normally, then a write coincident with rst is lost
        drive(4'h3, 4'hF, 4'h6, 1'b0, 64'h66, 64'h0, 1'b1);
        tick();
        peek("pre_rstwr_r6", 4'h6, 64'h66);
        @(negedge clk);
        drive(4'h3, 4'hF, 4'h6, 1'b0, 64'hAB, 64'h0, 1'b1);
        rst = 1'b1;
        tick();
        peek("rstwr_r6", 4'h6, 64'h0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        peek("post_rst_wr_r6", 4'h6, 64'hAB);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
